// File: rtl/resp_collect_ctrl.sv
// resp_collect_ctrl: accepts one response request, collects up to SLOTS
// words into one line, then presents that line downstream on a
// valid/ready handshake.
module resp_collect_ctrl #(
  parameter int DATA_W = 32,
  parameter int SLOTS  = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [IDX_W-1:0]        req_len,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLOTS*DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [IDX_W:0]          out_beats,
  output logic                    out_err,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [IDX_W:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]          len_q, len_d;
  logic [SLOTS*DATA_W-1:0]   data_q, data_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic [IDX_W:0]            beats_q, beats_d;
  logic                      err_q, err_d;
  logic                      valid_q, valid_d;

  logic [IDX_W:0]            len_ext;
  logic                      at_len;
  logic                      early_end;
  logic                      terminate;

  assign len_ext   = {1'b0, len_q};
  assign at_len    = (cnt_q == len_ext);
  assign early_end = in_last && (cnt_q < len_ext);
  // Either the expected count or the source's last marker ends the line,
  // so cnt never indexes beyond the final slot.
  assign terminate = at_len || in_last;

  assign req_ready = (state_q == IDLE);
  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_beats = beats_q;
  assign out_err   = err_q;

  // State and datapath registers; reset discards any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      beats_q <= beats_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update for request, collection and output phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    tag_d   = tag_q;
    beats_d = beats_q;
    err_d   = err_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          len_d   = req_len;
          tag_d   = req_tag;
          data_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < SLOTS; k++) begin
            if (cnt_q[IDX_W-1:0] == k[IDX_W-1:0]) begin
              data_d[k*DATA_W +: DATA_W] = in_data;
            end
          end
          cnt_d   = cnt_q + ONE;
          beats_d = cnt_q + ONE;
          if (terminate) begin
            err_d   = early_end || (at_len && !in_last);
            valid_d = 1'b1;
            state_d = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_resp_collect_ctrl.sv
// Self-checking bench for resp_collect_ctrl: directed scenarios plus
// randomized lines checked against a line-level reference model.
module tb_resp_collect_ctrl;

  localparam int DATA_W = 32;
  localparam int SLOTS  = 8;
  localparam int IDX_W  = 3;
  localparam int TAG_W  = 4;
  localparam int LINE_W = SLOTS * DATA_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_len;
  logic [TAG_W-1:0]    req_tag;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [LINE_W-1:0]   out_data;
  logic [TAG_W-1:0]    out_tag;
  logic [IDX_W:0]      out_beats;
  logic                out_err;
  logic                busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DATA_W-1:0] words [SLOTS];

  resp_collect_ctrl #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .req_tag   (req_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_beats (out_beats),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. last_idx >= SLOTS means in_last is never sent.
  // gap_mode: 0 none, 1 one idle cycle before every beat after the first,
  // 2 random idle cycles.
  task automatic run_line(input int unsigned len, input int unsigned tag,
                          input int unsigned last_idx, input int unsigned gap_mode,
                          input int unsigned stall, input bit poke_inputs);
    int unsigned       beats;
    bit                err;
    logic [LINE_W-1:0] exp_line;

    // Reference: the line ends at the first in_last or after len+1 words,
    // whichever comes first; a disagreement between the two is an error.
    beats    = (last_idx <= len) ? last_idx + 1 : len + 1;
    err      = (last_idx != len);
    exp_line = '0;
    for (int k = 0; k < int'(beats); k++) exp_line[k*DATA_W +: DATA_W] = words[k];

    check_eq("idle_req_ready", req_ready, 1'b1);
    check_eq("idle_busy", busy, 1'b0);
    req_valid = 1'b1;
    req_len   = len[IDX_W-1:0];
    req_tag   = tag[TAG_W-1:0];
    tick();
    req_valid = 1'b0;
    check_eq("collect_busy", busy, 1'b1);
    check_eq("collect_req_ready", req_ready, 1'b0);
    check_eq("new_req_clears_data", out_data, '0);
    check_eq("new_req_clears_err", out_err, 1'b0);

    for (int k = 0; k < int'(beats); k++) begin
      if (gap_mode == 1 && k > 0) begin
        tick();
      end else if (gap_mode == 2) begin
        while ($urandom_range(0, 2) == 0) tick();
      end
      check_eq("pre_beat_out_valid", out_valid, 1'b0);
      check_eq("collect_in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = words[k];
      in_last  = (k == int'(last_idx));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end

    check_eq("out_valid_rise", out_valid, 1'b1);
    check_eq("out_data", out_data, exp_line);
    check_eq("out_tag", out_tag, tag[TAG_W-1:0]);
    check_eq("out_beats", out_beats, beats[IDX_W:0]);
    check_eq("out_err", out_err, err);
    check_eq("output_in_ready", in_ready, 1'b0);
    check_eq("output_req_ready", req_ready, 1'b0);

    for (int s = 0; s < int'(stall); s++) begin
      if (poke_inputs) begin
        req_valid = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
      end
      tick();
      check_eq("stall_out_valid", out_valid, 1'b1);
      check_eq("stall_out_data", out_data, exp_line);
      check_eq("stall_in_ready", in_ready, 1'b0);
      check_eq("stall_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    in_valid  = 1'b0;

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 1'b0);
    check_eq("post_busy", busy, 1'b0);
    check_eq("post_data_kept", out_data, exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_len   = '0;
    req_tag   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_tag", out_tag, '0);
    check_eq("rst_out_beats", out_beats, '0);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("idle_in_ready", in_ready, 1'b0);
    check_eq("idle_req_ready0", req_ready, 1'b1);

    // Full 8-beat line, no stalls.
    for (int k = 0; k < SLOTS; k++) words[k] = 32'h11111111 * (k + 1);
    run_line(7, 5, 7, 0, 0, 1'b0);

    // Short 2-beat line.
    words[0] = 32'hAAAA0001;
    words[1] = 32'hBBBB0002;
    run_line(1, 3, 1, 0, 0, 1'b0);

    // Early last on the third word.
    for (int k = 0; k < SLOTS; k++) words[k] = $urandom;
    run_line(7, 9, 2, 0, 0, 1'b0);

    // Gaps between beats and a 5-cycle output stall with ignored inputs.
    for (int k = 0; k < SLOTS; k++) words[k] = $urandom;
    run_line(5, 12, 5, 1, 5, 1'b1);

    // Missing last on a single-beat request.
    words[0] = 32'hDEADBEEF;
    run_line(0, 1, 8, 0, 0, 1'b0);

    // Asynchronous reset after 4 of 8 beats.
    for (int k = 0; k < SLOTS; k++) words[k] = $urandom;
    req_valid = 1'b1;
    req_len   = 3'd7;
    req_tag   = 4'd6;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = words[k];
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_out_data", out_data, '0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_out_err", out_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_line(7, 10, 7, 0, 0, 1'b0);

    // Randomized lines.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < SLOTS; k++) words[k] = $urandom;
      run_line($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 8),
               2, $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/resp_collect_ctrl.md
Name: resp_collect_ctrl

Overview:
Sequencing controller for response-line assembly. It accepts one response request (beat count plus tag) and collects up to 8 32-bit response words over a valid/ready stream. Each word is steered into its slot of a 256-bit line, and the completed line is presented downstream on a valid/ready handshake. It sits between a word-wide response source and a line-wide consumer, and drives the slot index that selects the write lane.

Parameters:
DATA_W, 32, width of one response word
SLOTS, 8, number of word slots per line
IDX_W, 3, slot index width (log2 SLOTS)
TAG_W, 4, request tag width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  new request offered
req_ready  output  1  controller can accept a request
req_len  input  IDX_W  expected beats minus one (0 = 1 beat, 7 = 8 beats)
req_tag  input  TAG_W  request tag, returned with the line
in_valid  input  1  response word offered
in_ready  output  1  controller accepts a word
in_data  input  DATA_W  response word
in_last  input  1  source marks the final word
out_valid  output  1  assembled line available
out_ready  input  1  consumer accepts the line
out_data  output  SLOTS*DATA_W  assembled line; slot k occupies bits [32k+31:32k]
out_tag  output  TAG_W  tag of the line
out_beats  output  IDX_W+1  number of slots written (1..8)
out_err  output  1  beat count and in_last disagreed
busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset state: state=IDLE. All registered outputs are 0: out_valid, out_data, out_tag, out_beats, out_err, cnt, len_q. req_ready=1 and in_ready=0 while reset is deasserted in IDLE. Reset asserted mid-operation discards any partial line immediately and raises no error indication.
- State IDLE:
  - req_ready=1, in_ready=0, out_valid=0.
  - On req_valid: latch len_q=req_len and out_tag=req_tag, clear out_data to all zeros, clear cnt=0 and out_err=0, then go to COLLECT.
- State COLLECT:
  - in_ready=1, req_ready=0.
  - On each in_valid&in_ready: write in_data to slot cnt (other slots unchanged), set cnt=cnt+1, set out_beats=cnt+1.
  - Terminating beat: cnt==len_q OR in_last=1. On that beat go to OUTPUT and register out_valid=1. out_valid therefore rises the cycle after the final word handshake.
  - out_err=1 if in_last=1 while cnt<len_q (early end), or if cnt==len_q while in_last=0 (missing last).
  - Idle cycles with in_valid=0 hold all state; no timeout.
- State OUTPUT:
  - out_valid=1, in_ready=0, req_ready=0.
  - out_data, out_tag, out_beats and out_err are stable until the handshake.
  - On out_ready go to IDLE and clear out_valid. out_data keeps its value until the next request clears it.
- Throughput:
  - req_ready is asserted only in IDLE, so there is at least one IDLE cycle between lines.
  - An 8-beat line with no stalls takes 1 (request) + 8 (beats) + 1 (output) cycles.
- Width rules:
  - cnt is IDX_W+1 bits so the value 8 is representable.
  - The slot index is cnt[IDX_W-1:0].
  - No write can occur past slot 7, because the beat with cnt==len_q always terminates collection.
- Simultaneous events: req_valid in COLLECT or OUTPUT is ignored (req_ready=0). in_valid in IDLE or OUTPUT is not accepted.
- busy=1 in COLLECT and OUTPUT.

Test Plan:
1. Full line, no stalls:
   - Stimulus: req_len=7, req_tag=5, then words 0x11111111*(k+1) for k=0..7 with in_last on the 8th beat, out_ready=1.
   - Required: out_data[31:0]=0x11111111 and out_data[255:224]=0x88888888; out_beats=8, out_tag=5, out_err=0; out_valid rises 1 cycle after beat 8 and is high for one cycle.
2. Short line:
   - Stimulus: req_len=1, words 0xAAAA0001 then 0xBBBB0002 with in_last.
   - Required: out_data[63:0]=0xBBBB0002_AAAA0001, bits [255:64]=0, out_beats=2, out_err=0.
3. Early last:
   - Stimulus: req_len=7, in_last on the 3rd word.
   - Required: out_beats=3, out_err=1, slots 3..7 equal 0; a following request clears the previous data.
4. Backpressure and gaps:
   - Stimulus: in_valid toggled 1-0-1 between beats; out_ready held low for 5 cycles in OUTPUT.
   - Required: out_valid stays 1 and out_data is stable for the whole stall; in_ready=0 and req_ready=0 during the stall; IDLE is entered the cycle after out_ready=1.
5. Missing last:
   - Stimulus: req_len=0, a single word with in_last=0.
   - Required: out_beats=1, out_err=1.
6. Reset mid-collect:
   - Stimulus: assert rst asynchronously after 4 of 8 beats.
   - Required: out_valid=0, out_data=0 and busy=0 immediately; after release, a new 8-beat request completes correctly.
